vetris_input_ctrl: RTL and testbench
====================================

// Module: vetris_input_ctrl
// PURPOSE
//  Upstream feeder of the CPU in_reg_data port. Syncs and debounces raw player buttons and
//  generates the periodic gravity (move-down) request. Posts one move request at a time into
//  the 32-bit input register. Accepts CPU write-back of the whole register on
//  final_isMoveOrWriteShape, which is how the CPU clears/acknowledges a request.
// PARAMETERS
//  DEBOUNCE_CYCLES  4     cycles a synced button level must be stable before it is accepted
//  GRAVITY_CYCLES   1000  clk cycles between gravity move-down requests (>=2)
//  DROP_CNT_W       8     width of saturating dropped-event counter
// PORTS
//  clk                       in   1   system clock, all logic on posedge
//  rst                       in   1   asynchronous active-low reset
//  btn_left                  in   1   raw async button, 1 = pressed
//  btn_right                 in   1   raw async button
//  btn_down                  in   1   raw async button (soft drop)
//  btn_rotate                in   1   raw async button
//  pause                     in   1   1 = freeze gravity and block new requests
//  final_isMoveOrWriteShape  in   1   CPU write-back strobe
//  input_reg_update          in   32  CPU write-back value
//  in_reg_data               out  32  input register to CPU; [3:0] request, [31:4] CPU-owned
//  gravity_tick              out  1   1-cycle pulse when gravity counter wraps
//  dropped_events            out  DROP_CNT_W  saturating count of merged/blocked events
// BEHAVIOUR
//  Reset (rst=0, async): in_reg_data=0, gravity_tick=0, dropped_events=0. Also clears the
//   sync flops, debounced levels, debounce counters, gravity counter and pending flags.
//   Mid-operation reset drops all pending requests; no request survives reset.
//  Request field [3:0] is one-hot: 4'b0001 down, 4'b0010 left, 4'b0100 right, 4'b1000 rotate,
//   4'b0000 idle. [31:4] is written only by CPU write-back, never by this block.
//  Per button: 2-flop synchronizer, then debounce counter. Counter resets on any change of
//   synced level vs. debounced level. Debounced level takes the synced value once the
//   counter reaches DEBOUNCE_CYCLES. Press latency: DEBOUNCE_CYCLES+2 cycles from input to
//   debounced rise. A debounced 0->1 edge is a press event; release generates nothing.
//  Gravity: counter 0..GRAVITY_CYCLES-1, increments when pause=0 and holds when pause=1.
//   On wrap, gravity_tick=1 for one cycle and a down event is raised.
//  Pending flags (down, rotate, left, right): an event sets its flag. Events are dropped while
//   pause=1. An event whose flag is already set is merged. Every dropped or merged event
//   increments dropped_events, saturating at all-ones. btn_down and gravity share the down
//   flag; if both fire in the same cycle, one is accepted and one is merged (+1).
//  Each cycle, in priority order:
//   1) final_isMoveOrWriteShape=1: in_reg_data <= input_reg_update (all 32 bits). No load
//      this cycle.
//   2) else if in_reg_data[3:0]==0 and any flag is set: load the highest-priority flag
//      (down > rotate > left > right) into [3:0] and clear that flag. [31:4] is unchanged.
//   3) else hold.
//   Events arriving in a write-back or load cycle are still captured in the flags.
//  Latency: an event posted with an idle field appears in in_reg_data one cycle later.
//  The field stays nonzero until the CPU writes back. Back-to-back requests need one
//   write-back each.
//  A write-back with nonzero [3:0] is accepted as-is; the next load waits until [3:0] is 0.
// TESTING
//  1 Reset: hold rst=0 10 cycles with buttons toggling -> in_reg_data=0, gravity_tick=0,
//    dropped_events=0. Release -> first gravity_tick at cycle GRAVITY_CYCLES after release.
//  2 btn_left high 10 cycles (DEBOUNCE_CYCLES=4) -> in_reg_data[3:0]=4'b0010 exactly 7 cycles
//    after the rise. Then write-back 32'h0005_0150 -> in_reg_data=32'h0005_0150.
//  3 Bounce: btn_right toggling every 2 cycles for 20 cycles -> no request and no event.
//    Then stable high -> [3:0]=4'b0100.
//  4 Priority: set left, right, rotate pending with field busy. Write-back [3:0]=0 three
//    times -> loads 1000, then 0010, then 0100, each one cycle after its write-back.
//  5 Merge/pause: press left twice while field busy -> dropped_events=1. pause=1 across a
//    gravity wrap -> no tick; counter resumes from held value.
//  6 Write-back and press edge in the same cycle -> register takes input_reg_update; the
//    request loads the next cycle. Async reset mid-request -> all cleared immediately.

Source files
------------

// File: rtl/vetris_input_ctrl.sv
// vetris_input_ctrl: player input front end for the CPU input register.
// Synchronises and debounces the four buttons, generates periodic gravity
// move-down requests, and posts one one-hot move request at a time into
// in_reg_data[3:0]. The CPU acknowledges by writing the whole register back.
module vetris_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GRAVITY_CYCLES  = 1000,
    parameter int unsigned DROP_CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_down,
    input  logic                  btn_rotate,
    input  logic                  pause,
    input  logic                  final_isMoveOrWriteShape,
    input  logic [31:0]           input_reg_update,
    output logic [31:0]           in_reg_data,
    output logic                  gravity_tick,
    output logic [DROP_CNT_W-1:0] dropped_events
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned GV_W = $clog2(GRAVITY_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GV_W-1:0] GV_LAST = GV_W'(GRAVITY_CYCLES - 1);
    localparam int unsigned SUM_W = DROP_CNT_W + 3;

    // Bit order everywhere matches the request encoding: [0] down, [1] left,
    // [2] right, [3] rotate.
    logic [3:0]      w_btn_raw;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      r_db_lvl;
    logic [DB_W-1:0] r_db_cnt [4];
    logic [3:0]      w_db_done;
    logic [3:0]      w_press;

    logic [GV_W-1:0] r_grav_cnt;
    logic            w_grav_wrap;

    logic [3:0]      r_pend;
    logic [3:0]      w_accept;
    logic [3:0]      w_load_sel;
    logic            w_load_en;
    logic [3:0]      w_pend_nxt;
    logic [2:0]      w_ev_n;
    logic [2:0]      w_acc_n;
    logic [2:0]      w_drop_n;
    logic [SUM_W-1:0] w_drop_sum;

    assign w_btn_raw = {btn_rotate, btn_right, btn_left, btn_down};

    // Two-flop synchroniser for the raw asynchronous buttons.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce qualification and press detection; a press is flagged in the
    // same cycle the debounced level rises so the event is not delayed further.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            w_db_done[i] = (r_sync2[i] != r_db_lvl[i]) && (r_db_cnt[i] == DB_LAST);
            w_press[i]   = w_db_done[i] && r_sync2[i];
        end
    end

    // Debounce counters: restart whenever the synced level agrees with the
    // debounced level, accept the new level once it has been stable long enough.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_lvl <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_db_done[i]) begin
                    r_db_lvl[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_grav_wrap = !pause && (r_grav_cnt == GV_LAST);

    // Gravity counter, frozen while paused, with a one-cycle tick on wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grav_cnt   <= '0;
            gravity_tick <= 1'b0;
        end else begin
            gravity_tick <= w_grav_wrap;
            if (!pause) begin
                r_grav_cnt <= w_grav_wrap ? '0 : r_grav_cnt + 1'b1;
            end
        end
    end

    // Event acceptance, load selection and dropped-event accounting.
    // Dropped = all events this cycle minus those that newly set a flag; this
    // covers pause drops, merges into set flags and the down/gravity collision.
    always_comb begin
        w_accept = '0;
        if (!pause) begin
            w_accept    = w_press & ~r_pend;
            w_accept[0] = (w_press[0] || w_grav_wrap) && !r_pend[0];
        end

        w_ev_n  = 3'(w_grav_wrap);
        w_acc_n = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_ev_n  = w_ev_n + 3'(w_press[i]);
            w_acc_n = w_acc_n + 3'(w_accept[i]);
        end
        w_drop_n   = w_ev_n - w_acc_n;
        w_drop_sum = SUM_W'(dropped_events) + SUM_W'(w_drop_n);

        w_load_sel = '0;
        if (r_pend[0]) begin
            w_load_sel = 4'b0001;
        end else if (r_pend[3]) begin
            w_load_sel = 4'b1000;
        end else if (r_pend[1]) begin
            w_load_sel = 4'b0010;
        end else if (r_pend[2]) begin
            w_load_sel = 4'b0100;
        end
        w_load_en = !final_isMoveOrWriteShape && (in_reg_data[3:0] == 4'b0000) && (r_pend != 4'b0000);

        w_pend_nxt = (r_pend & ~(w_load_en ? w_load_sel : 4'b0000)) | w_accept;
    end

    // Pending flags and saturating dropped-event counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend         <= '0;
            dropped_events <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (|w_drop_sum[SUM_W-1:DROP_CNT_W]) begin
                dropped_events <= '1;
            end else begin
                dropped_events <= w_drop_sum[DROP_CNT_W-1:0];
            end
        end
    end

    // Input register: CPU write-back wins, otherwise post a request into an idle field.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_reg_data <= '0;
        end else if (final_isMoveOrWriteShape) begin
            in_reg_data <= input_reg_update;
        end else if (w_load_en) begin
            in_reg_data[3:0] <= w_load_sel;
        end
    end

endmodule

// File: tb/tb_vetris_input_ctrl.sv
// Directed testbench for vetris_input_ctrl (DEBOUNCE_CYCLES=4, GRAVITY_CYCLES=100,
// DROP_CNT_W=3 so saturation is reachable quickly).
module tb_vetris_input_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_left;
    logic        btn_right;
    logic        btn_down;
    logic        btn_rotate;
    logic        pause;
    logic        final_isMoveOrWriteShape;
    logic [31:0] input_reg_update;
    logic [31:0] in_reg_data;
    logic        gravity_tick;
    logic [2:0]  dropped_events;

    int errors = 0;
    int checks = 0;

    vetris_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .GRAVITY_CYCLES (100),
        .DROP_CNT_W     (3)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .btn_left                 (btn_left),
        .btn_right                (btn_right),
        .btn_down                 (btn_down),
        .btn_rotate               (btn_rotate),
        .pause                    (pause),
        .final_isMoveOrWriteShape (final_isMoveOrWriteShape),
        .input_reg_update         (input_reg_update),
        .in_reg_data              (in_reg_data),
        .gravity_tick             (gravity_tick),
        .dropped_events           (dropped_events)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btns(input logic [3:0] v);
        {btn_rotate, btn_right, btn_left, btn_down} = v;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        set_btns(4'b0000);
        pause = 1'b0;
        final_isMoveOrWriteShape = 1'b0;
        input_reg_update = '0;
        step(3);
        rst = 1'b1;
    endtask

    task automatic write_back(input logic [31:0] v);
        final_isMoveOrWriteShape = 1'b1;
        input_reg_update = v;
        step(1);
        final_isMoveOrWriteShape = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b0;
        pause = 1'b0;
        final_isMoveOrWriteShape = 1'b0;
        input_reg_update = '0;
        for (int i = 0; i < 10; i++) begin
            set_btns(4'(i) ^ 4'b0101);
            step(1);
        end
        set_btns(4'b0000);
        step(2);
        checks++; if (in_reg_data !== 32'h0) begin errors++; $display("FAIL reset_reg: got %h expected %h", in_reg_data, 32'h0); end
        checks++; if (gravity_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", gravity_tick); end
        checks++; if (dropped_events !== 3'd0) begin errors++; $display("FAIL reset_dropped: got %0d expected 0", dropped_events); end
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 99; i++) begin
            step(1);
            if (gravity_tick === 1'b1) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL reset_early_ticks: got %0d expected 0", n); end
        step(1);
        checks++; if (gravity_tick !== 1'b1) begin errors++; $display("FAIL reset_first_tick: got %b expected 1", gravity_tick); end
        step(1);
        checks++; if (gravity_tick !== 1'b0) begin errors++; $display("FAIL reset_tick_pulse: got %b expected 0", gravity_tick); end
        checks++; if (in_reg_data !== 32'h1) begin errors++; $display("FAIL reset_grav_req: got %h expected %h", in_reg_data, 32'h1); end
    endtask

    task automatic test_left_press;
        do_reset();
        btn_left = 1'b1;
        step(6);
        checks++; if (in_reg_data[3:0] !== 4'b0000) begin errors++; $display("FAIL left_early: got %b expected 0000", in_reg_data[3:0]); end
        step(1);
        checks++; if (in_reg_data[3:0] !== 4'b0010) begin errors++; $display("FAIL left_latency: got %b expected 0010", in_reg_data[3:0]); end
        step(3);
        btn_left = 1'b0;
        step(8);
        write_back(32'h0005_0150);
        checks++; if (in_reg_data !== 32'h0005_0150) begin errors++; $display("FAIL left_writeback: got %h expected %h", in_reg_data, 32'h0005_0150); end
        step(3);
        checks++; if (in_reg_data !== 32'h0005_0150) begin errors++; $display("FAIL left_hold: got %h expected %h", in_reg_data, 32'h0005_0150); end
        checks++; if (dropped_events !== 3'd0) begin errors++; $display("FAIL left_dropped: got %0d expected 0", dropped_events); end
    endtask

    task automatic test_bounce;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            btn_right = 1'b1;
            step(2);
            btn_right = 1'b0;
            step(2);
        end
        step(4);
        checks++; if (in_reg_data !== 32'h0) begin errors++; $display("FAIL bounce_no_req: got %h expected %h", in_reg_data, 32'h0); end
        checks++; if (dropped_events !== 3'd0) begin errors++; $display("FAIL bounce_no_event: got %0d expected 0", dropped_events); end
        btn_right = 1'b1;
        step(6);
        checks++; if (in_reg_data[3:0] !== 4'b0000) begin errors++; $display("FAIL bounce_stable_early: got %b expected 0000", in_reg_data[3:0]); end
        step(1);
        checks++; if (in_reg_data[3:0] !== 4'b0100) begin errors++; $display("FAIL bounce_stable_req: got %b expected 0100", in_reg_data[3:0]); end
        btn_right = 1'b0;
    endtask

    task automatic test_priority;
        do_reset();
        write_back(32'h1234_5678);
        set_btns(4'b1110);
        step(8);
        set_btns(4'b0000);
        step(8);
        checks++; if (in_reg_data !== 32'h1234_5678) begin errors++; $display("FAIL prio_busy: got %h expected %h", in_reg_data, 32'h1234_5678); end
        checks++; if (dropped_events !== 3'd0) begin errors++; $display("FAIL prio_dropped: got %0d expected 0", dropped_events); end
        write_back(32'h1234_5670);
        checks++; if (in_reg_data !== 32'h1234_5670) begin errors++; $display("FAIL prio_wb1: got %h expected %h", in_reg_data, 32'h1234_5670); end
        step(1);
        checks++; if (in_reg_data !== 32'h1234_5678) begin errors++; $display("FAIL prio_rotate: got %h expected %h", in_reg_data, 32'h1234_5678); end
        write_back(32'h0000_00A0);
        checks++; if (in_reg_data !== 32'h0000_00A0) begin errors++; $display("FAIL prio_wb2: got %h expected %h", in_reg_data, 32'h0000_00A0); end
        step(1);
        checks++; if (in_reg_data !== 32'h0000_00A2) begin errors++; $display("FAIL prio_left: got %h expected %h", in_reg_data, 32'h0000_00A2); end
        write_back(32'h0);
        checks++; if (in_reg_data !== 32'h0) begin errors++; $display("FAIL prio_wb3: got %h expected %h", in_reg_data, 32'h0); end
        step(1);
        checks++; if (in_reg_data !== 32'h4) begin errors++; $display("FAIL prio_right: got %h expected %h", in_reg_data, 32'h4); end
        step(2);
        checks++; if (in_reg_data !== 32'h4) begin errors++; $display("FAIL prio_hold: got %h expected %h", in_reg_data, 32'h4); end
    endtask

    task automatic test_merge;
        do_reset();
        write_back(32'h1);
        btn_left = 1'b1; step(8);
        btn_left = 1'b0; step(8);
        checks++; if (dropped_events !== 3'd0) begin errors++; $display("FAIL merge_first: got %0d expected 0", dropped_events); end
        btn_left = 1'b1; step(8);
        btn_left = 1'b0; step(8);
        checks++; if (dropped_events !== 3'd1) begin errors++; $display("FAIL merge_second: got %0d expected 1", dropped_events); end
        checks++; if (in_reg_data !== 32'h1) begin errors++; $display("FAIL merge_busy: got %h expected %h", in_reg_data, 32'h1); end
        write_back(32'h0);
        step(1);
        checks++; if (in_reg_data !== 32'h2) begin errors++; $display("FAIL merge_load: got %h expected %h", in_reg_data, 32'h2); end
        write_back(32'h0);
        step(2);
        checks++; if (in_reg_data !== 32'h0) begin errors++; $display("FAIL merge_single: got %h expected %h", in_reg_data, 32'h0); end
    endtask

    task automatic test_saturate;
        do_reset();
        pause = 1'b1;
        set_btns(4'b1111); step(8);
        set_btns(4'b0000); step(8);
        checks++; if (dropped_events !== 3'd4) begin errors++; $display("FAIL sat_four: got %0d expected 4", dropped_events); end
        set_btns(4'b1111); step(8);
        set_btns(4'b0000); step(8);
        checks++; if (dropped_events !== 3'd7) begin errors++; $display("FAIL sat_clamp: got %0d expected 7", dropped_events); end
        checks++; if (in_reg_data !== 32'h0) begin errors++; $display("FAIL sat_no_req: got %h expected %h", in_reg_data, 32'h0); end
        pause = 1'b0;
    endtask

    task automatic test_pause_gravity;
        int n;
        do_reset();
        step(90);
        pause = 1'b1;
        btn_rotate = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (gravity_tick === 1'b1) n++;
        end
        btn_rotate = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (gravity_tick === 1'b1) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL pause_no_tick: got %0d expected 0", n); end
        checks++; if (dropped_events !== 3'd1) begin errors++; $display("FAIL pause_drop: got %0d expected 1", dropped_events); end
        pause = 1'b0;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            step(1);
            if (gravity_tick === 1'b1) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL pause_resume_early: got %0d expected 0", n); end
        step(1);
        checks++; if (gravity_tick !== 1'b1) begin errors++; $display("FAIL pause_resume_tick: got %b expected 1", gravity_tick); end
        step(1);
        checks++; if (in_reg_data !== 32'h1) begin errors++; $display("FAIL pause_grav_req: got %h expected %h", in_reg_data, 32'h1); end
    endtask

    task automatic test_down_merge;
        do_reset();
        step(94);
        btn_down = 1'b1;
        step(5);
        checks++; if (dropped_events !== 3'd0) begin errors++; $display("FAIL down_pre: got %0d expected 0", dropped_events); end
        step(1);
        checks++; if (gravity_tick !== 1'b1) begin errors++; $display("FAIL down_tick: got %b expected 1", gravity_tick); end
        checks++; if (dropped_events !== 3'd1) begin errors++; $display("FAIL down_collide: got %0d expected 1", dropped_events); end
        step(1);
        checks++; if (in_reg_data !== 32'h1) begin errors++; $display("FAIL down_req: got %h expected %h", in_reg_data, 32'h1); end
        btn_down = 1'b0;
    endtask

    task automatic test_back_to_back;
        do_reset();
        step(2);
        btn_left = 1'b1;
        step(5);
        write_back(32'h0000_0300);
        checks++; if (in_reg_data !== 32'h0000_0300) begin errors++; $display("FAIL b2b_wb_wins: got %h expected %h", in_reg_data, 32'h0000_0300); end
        step(1);
        checks++; if (in_reg_data !== 32'h0000_0302) begin errors++; $display("FAIL b2b_next_load: got %h expected %h", in_reg_data, 32'h0000_0302); end
        step(1);
        btn_left = 1'b0;
        btn_right = 1'b1;
        step(8);
        btn_right = 1'b0;
        step(4);
        checks++; if (in_reg_data !== 32'h0000_0302) begin errors++; $display("FAIL b2b_busy: got %h expected %h", in_reg_data, 32'h0000_0302); end
        #3;
        rst = 1'b0;
        #1;
        checks++; if (in_reg_data !== 32'h0) begin errors++; $display("FAIL async_rst_reg: got %h expected %h", in_reg_data, 32'h0); end
        checks++; if (gravity_tick !== 1'b0) begin errors++; $display("FAIL async_rst_tick: got %b expected 0", gravity_tick); end
        checks++; if (dropped_events !== 3'd0) begin errors++; $display("FAIL async_rst_dropped: got %0d expected 0", dropped_events); end
        step(2);
        rst = 1'b1;
        step(10);
        checks++; if (in_reg_data !== 32'h0) begin errors++; $display("FAIL async_rst_pending: got %h expected %h", in_reg_data, 32'h0); end
    endtask

    initial begin
        rst = 1'b0;
        set_btns(4'b0000);
        pause = 1'b0;
        final_isMoveOrWriteShape = 1'b0;
        input_reg_update = '0;
        test_reset();
        test_left_press();
        test_bounce();
        test_priority();
        test_merge();
        test_saturate();
        test_pause_gravity();
        test_down_merge();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
